fft_stream_host: RTL and testbench

- Host-side counterpart of the FFT AXI bridge: the initiator that drives the bridge's sample-write channel and sinks its result-read channel.
- Pulls N 16-bit samples from an upstream sample source and presents them on the AW channel (o_AWDATA/o_AWVALID/i_AWREADY).
- Waits for calculation results, accepts N result words on the AR channel (i_ARDATA/i_ARVALID/o_ARREADY) and forwards them, indexed, to a downstream result sink.

---
 rtl/fft_stream_host_if.sv | 29 ++
 rtl/fft_stream_host.sv | 229 ++++++++++++++++++++++
 tb/tb_fft_stream_host.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fft_stream_host_if.sv
// fft_stream_host_if
// Channel bundle between the FFT stream host and the FFT AXI bridge.
//   AW side : o_AWDATA / o_AWVALID (host -> bridge), i_AWREADY (bridge -> host)
//   status  : i_DATA_LOADED (bridge -> host), high with the last sample write
//   AR side : i_ARDATA / i_ARVALID (bridge -> host), o_ARREADY (host -> bridge)
// Signal names keep the host's point of view, so "o_" means driven by the host.
// master modport : the host (initiator)
// slave modport  : the bridge
interface fft_stream_host_if #(
  parameter int DATA_WIDTH = 32
);
  logic [15:0]           o_AWDATA;
  logic                  o_AWVALID;
  logic                  i_AWREADY;
  logic                  i_DATA_LOADED;
  logic                  i_ARVALID;
  logic [DATA_WIDTH-1:0] i_ARDATA;
  logic                  o_ARREADY;

  modport master (
    output o_AWDATA, o_AWVALID, o_ARREADY,
    input  i_AWREADY, i_DATA_LOADED, i_ARVALID, i_ARDATA
  );

  modport slave (
    input  o_AWDATA, o_AWVALID, o_ARREADY,
    output i_AWREADY, i_DATA_LOADED, i_ARVALID, i_ARDATA
  );
endinterface

// File: rtl/fft_stream_host.sv
// fft_stream_host
// Host-side initiator for the FFT AXI bridge. One frame:
//   1. accept i_START with a non-zero length N (latched),
//   2. move N 16-bit samples from the upstream source onto the bridge AW channel,
//   3. wait for results, take N result words from the AR channel and forward
//      each to the downstream sink together with its bin index 0..N-1,
//   4. pulse o_DONE once the last result has left the output register.
// Ports:
//   i_clk, i_rst            clock (rising edge), asynchronous active-high reset
//   i_START, i_ABORT        frame start (IDLE only) / synchronous abort
//   i_SAMPLES_NUMBER        frame length N
//   i_SRC_VALID/DATA,
//   o_SRC_READY             upstream sample source
//   bridge                  AW/AR channels and i_DATA_LOADED (master modport)
//   o_RES_VALID/DATA/INDEX,
//   i_RES_READY             downstream result sink (registered outputs)
//   o_BUSY, o_DONE, o_ERROR frame status; o_ERROR is sticky until next start
module fft_stream_host #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 12
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_START,
  input  logic                  i_ABORT,
  input  logic [CNT_WIDTH-1:0]  i_SAMPLES_NUMBER,
  input  logic                  i_SRC_VALID,
  input  logic [15:0]           i_SRC_DATA,
  output logic                  o_SRC_READY,
  fft_stream_host_if.master     bridge,
  output logic                  o_RES_VALID,
  output logic [DATA_WIDTH-1:0] o_RES_DATA,
  output logic [CNT_WIDTH-1:0]  o_RES_INDEX,
  input  logic                  i_RES_READY,
  output logic                  o_BUSY,
  output logic                  o_DONE,
  output logic                  o_ERROR
);

  typedef enum logic [2:0] {
    IDLE,
    SEND,
    WAIT_CALC,
    RECV,
    DONE
  } state_t;

  state_t state, state_nx;

  logic [CNT_WIDTH-1:0]  n_lat;
  logic [CNT_WIDTH-1:0]  last_idx;
  logic [CNT_WIDTH-1:0]  load_cnt;
  logic [CNT_WIDTH-1:0]  ack_cnt;
  logic [CNT_WIDTH-1:0]  rcv_cnt;

  logic [15:0]           aw_data_q;
  logic                  aw_valid_q;
  logic                  res_valid_q;
  logic [DATA_WIDTH-1:0] res_data_q;
  logic [CNT_WIDTH-1:0]  res_index_q;
  logic                  done_q;
  logic                  error_q;

  logic start_acc;
  logic start_zero;
  logic abort_act;
  logic src_ready;
  logic ar_ready;
  logic src_hs;
  logic aw_hs;
  logic ar_hs;
  logic sink_hs;
  logic last_ack;
  logic last_rcv;
  logic dl_error;
  logic done_fire;

  // n_lat is never zero outside IDLE, so last_idx cannot wrap while it matters.
  assign last_idx   = n_lat - CNT_WIDTH'(1);
  assign last_ack   = (ack_cnt == last_idx);
  assign last_rcv   = (rcv_cnt == last_idx);

  assign start_acc  = (state == IDLE) && i_START && (i_SAMPLES_NUMBER != '0);
  assign start_zero = (state == IDLE) && i_START && (i_SAMPLES_NUMBER == '0);
  assign abort_act  = i_ABORT && (state != IDLE);

  // Both ready signals are withheld during an abort so that neither side
  // believes a transfer happened in a cycle whose state is being discarded.
  assign src_ready  = (state == SEND) && !i_ABORT && (load_cnt < n_lat) &&
                      (!aw_valid_q || bridge.i_AWREADY);
  assign ar_ready   = ((state == WAIT_CALC) || (state == RECV)) && !i_ABORT &&
                      (!res_valid_q || i_RES_READY);

  assign src_hs     = src_ready && i_SRC_VALID;
  assign aw_hs      = (state == SEND) && aw_valid_q && bridge.i_AWREADY;
  assign ar_hs      = ar_ready && bridge.i_ARVALID;
  assign sink_hs    = res_valid_q && i_RES_READY;

  // The bridge may only flag "loaded" together with the final AW handshake.
  assign dl_error   = (state == SEND) && bridge.i_DATA_LOADED && !(aw_hs && last_ack);

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic. With N==1 the first AR handshake is also the last one,
  // so WAIT_CALC may go straight to DONE. Abort overrides everything.
  always_comb begin
    state_nx  = state;
    done_fire = 1'b0;
    case (state)
      IDLE: begin
        if (start_acc) state_nx = SEND;
      end
      SEND: begin
        if (aw_hs && last_ack) state_nx = WAIT_CALC;
      end
      WAIT_CALC: begin
        if (ar_hs) state_nx = last_rcv ? DONE : RECV;
      end
      RECV: begin
        if (ar_hs && last_rcv) state_nx = DONE;
      end
      DONE: begin
        if (!res_valid_q || i_RES_READY) begin
          done_fire = 1'b1;
          state_nx  = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
    if (abort_act) begin
      state_nx  = IDLE;
      done_fire = 1'b0;
    end
  end

  // Frame length and progress counters. A start only happens in IDLE, so it
  // never coincides with any handshake.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      n_lat    <= '0;
      load_cnt <= '0;
      ack_cnt  <= '0;
      rcv_cnt  <= '0;
    end else if (abort_act) begin
      load_cnt <= '0;
      ack_cnt  <= '0;
      rcv_cnt  <= '0;
    end else begin
      if (start_acc) begin
        n_lat    <= i_SAMPLES_NUMBER;
        load_cnt <= '0;
        ack_cnt  <= '0;
        rcv_cnt  <= '0;
      end
      if (src_hs) load_cnt <= load_cnt + CNT_WIDTH'(1);
      if (aw_hs)  ack_cnt  <= ack_cnt + CNT_WIDTH'(1);
      if (ar_hs)  rcv_cnt  <= rcv_cnt + CNT_WIDTH'(1);
    end
  end

  // AW output register: a new load replaces the word even when the current
  // one is being accepted in the same cycle, which gives one sample per cycle.
  // Without a load, an accepted word simply empties the register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      aw_data_q  <= '0;
      aw_valid_q <= 1'b0;
    end else if (abort_act) begin
      aw_valid_q <= 1'b0;
    end else if (src_hs) begin
      aw_data_q  <= i_SRC_DATA;
      aw_valid_q <= 1'b1;
    end else if (aw_hs) begin
      aw_valid_q <= 1'b0;
    end
  end

  // Result output register, same replace-or-drain scheme as the AW side.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_index_q <= '0;
    end else if (abort_act) begin
      res_valid_q <= 1'b0;
    end else if (ar_hs) begin
      res_valid_q <= 1'b1;
      res_data_q  <= bridge.i_ARDATA;
      res_index_q <= rcv_cnt;
    end else if (sink_hs) begin
      res_valid_q <= 1'b0;
    end
  end

  // Status flags: o_DONE is a registered one-cycle pulse, o_ERROR is sticky
  // and only an accepted start clears it.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      done_q <= done_fire;
      if (abort_act || start_zero || dl_error) begin
        error_q <= 1'b1;
      end else if (start_acc) begin
        error_q <= 1'b0;
      end
    end
  end

  assign o_SRC_READY      = src_ready;
  assign bridge.o_AWDATA  = aw_data_q;
  assign bridge.o_AWVALID = aw_valid_q;
  assign bridge.o_ARREADY = ar_ready;
  assign o_RES_VALID      = res_valid_q;
  assign o_RES_DATA       = res_data_q;
  assign o_RES_INDEX      = res_index_q;
  assign o_BUSY           = (state != IDLE);
  assign o_DONE           = done_q;
  assign o_ERROR          = error_q;

endmodule

// File: tb/tb_fft_stream_host.sv
// tb_fft_stream_host
// Directed bench for fft_stream_host. The bench plays both the upstream
// source and the bridge; every frame pushes its expected AW words and
// expected (index, result) pairs into scoreboards that are popped on each
// observed handshake. All DUT outputs are sampled on the falling edge.
module tb_fft_stream_host;
  localparam int DW = 32;
  localparam int CW = 12;

  logic          i_clk = 1'b0;
  logic          i_rst = 1'b1;
  logic          i_START = 1'b0;
  logic          i_ABORT = 1'b0;
  logic [CW-1:0] i_SAMPLES_NUMBER = '0;
  logic          i_SRC_VALID = 1'b0;
  logic [15:0]   i_SRC_DATA = '0;
  logic          o_SRC_READY;
  logic          o_RES_VALID;
  logic [DW-1:0] o_RES_DATA;
  logic [CW-1:0] o_RES_INDEX;
  logic          i_RES_READY = 1'b1;
  logic          o_BUSY;
  logic          o_DONE;
  logic          o_ERROR;

  fft_stream_host_if #(.DATA_WIDTH(DW)) bus ();

  fft_stream_host #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .i_clk            (i_clk),
    .i_rst            (i_rst),
    .i_START          (i_START),
    .i_ABORT          (i_ABORT),
    .i_SAMPLES_NUMBER (i_SAMPLES_NUMBER),
    .i_SRC_VALID      (i_SRC_VALID),
    .i_SRC_DATA       (i_SRC_DATA),
    .o_SRC_READY      (o_SRC_READY),
    .bridge           (bus),
    .o_RES_VALID      (o_RES_VALID),
    .o_RES_DATA       (o_RES_DATA),
    .o_RES_INDEX      (o_RES_INDEX),
    .i_RES_READY      (i_RES_READY),
    .o_BUSY           (o_BUSY),
    .o_DONE           (o_DONE),
    .o_ERROR          (o_ERROR)
  );

  always #5 i_clk = ~i_clk;

  int tests_run = 0;
  int tests_failed = 0;
  int done_cnt = 0;

  logic [15:0]      src_q[$];
  logic [15:0]      aw_exp_q[$];
  logic [DW-1:0]    ar_q[$];
  logic [DW+CW-1:0] res_exp_q[$];

  logic        nb_src_ready;
  logic        nb_arready;
  logic        nb_awvalid;
  logic [15:0] nb_awdata;
  logic        nb_aw_hs;

  // Generic comparison point.
  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp)
    else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Source and bridge-result drivers follow the heads of their queues.
  task automatic applyStimulus();
    i_SRC_VALID   = (src_q.size() > 0);
    i_SRC_DATA    = (src_q.size() > 0) ? src_q[0] : 16'h0;
    bus.i_ARVALID = (ar_q.size() > 0);
    bus.i_ARDATA  = (ar_q.size() > 0) ? ar_q[0] : '0;
  endtask

  // One clock: sample and score on the falling edge, then advance the
  // drivers just after the rising edge.
  task automatic tick();
    logic             s_hs;
    logic             a_hs;
    logic [DW+CW-1:0] e;
    @(negedge i_clk);
    nb_src_ready = o_SRC_READY;
    nb_arready   = bus.o_ARREADY;
    nb_awvalid   = bus.o_AWVALID;
    nb_awdata    = bus.o_AWDATA;
    nb_aw_hs     = bus.o_AWVALID && bus.i_AWREADY;
    if (o_DONE) done_cnt++;
    if (nb_aw_hs) begin
      checkOutput("aw_expected", aw_exp_q.size() > 0, 1);
      if (aw_exp_q.size() > 0) checkOutput("aw_data", bus.o_AWDATA, aw_exp_q.pop_front());
    end
    if (o_RES_VALID && i_RES_READY) begin
      checkOutput("res_expected", res_exp_q.size() > 0, 1);
      if (res_exp_q.size() > 0) begin
        e = res_exp_q.pop_front();
        checkOutput("res_data", o_RES_DATA, e[DW-1:0]);
        checkOutput("res_index", o_RES_INDEX, e[DW+CW-1:DW]);
      end
    end
    s_hs = i_SRC_VALID && o_SRC_READY;
    a_hs = bus.i_ARVALID && bus.o_ARREADY;
    @(posedge i_clk);
    #1;
    if (s_hs) void'(src_q.pop_front());
    if (a_hs) void'(ar_q.pop_front());
    applyStimulus();
  endtask

  // Start a frame and push its samples through. AW ready drops for cycles
  // [ss, ss+sl) counted from the first SEND cycle; i_DATA_LOADED is raised
  // with the last AW handshake and additionally in cycle dl_bad.
  task automatic sendFrame(input int n, input logic [15:0] base, input int ss, input int sl,
                           input int dl_bad, output int rdy_cycles, output int rdy_in_stall,
                           output int first_beat, output int last_beat, output int hold2,
                           output int arr_cycles, output logic err_after_start,
                           output logic busy_after_start);
    rdy_cycles = 0; rdy_in_stall = 0; first_beat = -1; last_beat = -1;
    hold2 = 0; arr_cycles = 0;
    for (int i = 0; i < n; i++) begin
      src_q.push_back(base + 16'(i));
      aw_exp_q.push_back(base + 16'(i));
    end
    applyStimulus();
    i_SAMPLES_NUMBER = CW'(n);
    i_START = 1'b1;
    tick();
    i_START = 1'b0;
    err_after_start  = o_ERROR;
    busy_after_start = o_BUSY;
    for (int j = 0; j < 100 && aw_exp_q.size() > 0; j++) begin
      bus.i_AWREADY     = !(j >= ss && j < ss + sl);
      bus.i_DATA_LOADED = (j == dl_bad) ||
                          (bus.i_AWREADY && bus.o_AWVALID && aw_exp_q.size() == 1);
      tick();
      if (nb_src_ready) begin
        rdy_cycles++;
        if (j >= ss && j < ss + sl) rdy_in_stall++;
      end
      if (nb_aw_hs) begin
        if (first_beat < 0) first_beat = j;
        last_beat = j;
      end
      if (nb_awvalid && nb_awdata == base + 16'd1) hold2++;
      if (nb_arready) arr_cycles++;
    end
    bus.i_AWREADY     = 1'b1;
    bus.i_DATA_LOADED = 1'b0;
    checkOutput("aw_drained", aw_exp_q.size(), 0);
  endtask

  // Deliver n results base, base+1, ... and drain them; the sink stalls in
  // loop cycle stall_k. Counts o_DONE pulses up to three cycles past the first.
  task automatic recvFrame(input int n, input logic [DW-1:0] base, input int stall_k,
                           output int arr_cycles, output logic arr_first,
                           output logic arr_stall, output int dones);
    int d0;
    arr_cycles = 0; arr_first = 1'b0; arr_stall = 1'b0;
    for (int i = 0; i < n; i++) begin
      ar_q.push_back(base + DW'(i));
      res_exp_q.push_back({CW'(i), base + DW'(i)});
    end
    applyStimulus();
    d0 = done_cnt;
    for (int k = 0; k < 100 && done_cnt == d0; k++) begin
      i_RES_READY = (k != stall_k);
      tick();
      if (nb_arready) arr_cycles++;
      if (k == 0) arr_first = nb_arready;
      if (k == stall_k) arr_stall = nb_arready;
    end
    i_RES_READY = 1'b1;
    repeat (3) tick();
    dones = done_cnt - d0;
    checkOutput("res_drained", res_exp_q.size(), 0);
  endtask

  // Watchdog so a stuck DUT still ends the run.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: observed timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int   rc, rs, fb, lb, h2, ac, arc, dn, d0;
    logic ea, ba, af, ast;

    bus.i_AWREADY     = 1'b1;
    bus.i_DATA_LOADED = 1'b0;
    bus.i_ARVALID     = 1'b0;
    bus.i_ARDATA      = '0;

    // Reset values, sampled while reset is still asserted.
    repeat (3) @(posedge i_clk);
    #1;
    checkOutput("rst_awvalid", bus.o_AWVALID, 0);
    checkOutput("rst_awdata", bus.o_AWDATA, 0);
    checkOutput("rst_res_valid", o_RES_VALID, 0);
    checkOutput("rst_res_data", o_RES_DATA, 0);
    checkOutput("rst_res_index", o_RES_INDEX, 0);
    checkOutput("rst_done", o_DONE, 0);
    checkOutput("rst_error", o_ERROR, 0);
    checkOutput("rst_busy", o_BUSY, 0);
    i_rst = 1'b0;
    tick();

    // Frame 1: N=4 streaming with AW always ready, results with one sink stall.
    sendFrame(4, 16'h0001, -1, 0, -1, rc, rs, fb, lb, h2, ac, ea, ba);
    checkOutput("f1_err_start", ea, 0);
    checkOutput("f1_busy_start", ba, 1);
    checkOutput("f1_src_ready_cycles", rc, 4);
    checkOutput("f1_first_beat", fb, 1);
    checkOutput("f1_beats_consecutive", lb - fb, 3);
    checkOutput("f1_arready_in_send", ac, 0);
    checkOutput("f1_wait_busy", o_BUSY, 1);
    checkOutput("f1_wait_awvalid", bus.o_AWVALID, 0);
    checkOutput("f1_error_after_send", o_ERROR, 0);
    recvFrame(4, 32'h000000A0, 1, arc, af, ast, dn);
    checkOutput("f1_arready_wait", af, 1);
    checkOutput("f1_arready_stall", ast, 0);
    checkOutput("f1_arready_cycles", arc, 4);
    checkOutput("f1_done_pulses", dn, 1);
    checkOutput("f1_idle", o_BUSY, 0);
    checkOutput("f1_error_end", o_ERROR, 0);

    // Frame 2: AW ready low for three cycles on the second beat.
    sendFrame(4, 16'h0001, 2, 3, -1, rc, rs, fb, lb, h2, ac, ea, ba);
    checkOutput("f2_hold_0002", h2, 4);
    checkOutput("f2_src_ready_in_stall", rs, 0);
    checkOutput("f2_src_ready_cycles", rc, 4);
    checkOutput("f2_last_beat", lb, 7);
    recvFrame(4, 32'h00001000, -1, arc, af, ast, dn);
    checkOutput("f2_done_pulses", dn, 1);
    checkOutput("f2_arready_cycles", arc, 4);

    // Zero-length start is refused and flags an error.
    i_SAMPLES_NUMBER = '0;
    i_START = 1'b1;
    tick();
    i_START = 1'b0;
    checkOutput("n0_error", o_ERROR, 1);
    checkOutput("n0_busy", o_BUSY, 0);
    tick();
    checkOutput("n0_busy_later", o_BUSY, 0);

    // A valid N=2 start clears the error.
    sendFrame(2, 16'h0020, -1, 0, -1, rc, rs, fb, lb, h2, ac, ea, ba);
    checkOutput("n2_err_cleared", ea, 0);
    checkOutput("n2_busy", ba, 1);
    recvFrame(2, 32'h12345670, -1, arc, af, ast, dn);
    checkOutput("n2_done_pulses", dn, 1);
    checkOutput("n2_error_end", o_ERROR, 0);

    // Early i_DATA_LOADED after the first of three samples.
    sendFrame(3, 16'h0030, -1, 0, 1, rc, rs, fb, lb, h2, ac, ea, ba);
    checkOutput("dl_error_set", o_ERROR, 1);
    recvFrame(3, 32'hCAFE0000, -1, arc, af, ast, dn);
    checkOutput("dl_done_pulses", dn, 1);
    checkOutput("dl_error_sticky", o_ERROR, 1);

    // Abort while result index 1 is waiting in the output register.
    sendFrame(4, 16'h0100, -1, 0, -1, rc, rs, fb, lb, h2, ac, ea, ba);
    checkOutput("ab_err_start", ea, 0);
    i_RES_READY = 1'b1;
    for (int i = 0; i < 4; i++) ar_q.push_back(32'hC0 + DW'(i));
    res_exp_q.push_back({CW'(0), 32'h000000C0});
    applyStimulus();
    tick();
    tick();
    checkOutput("ab_res_valid_before", o_RES_VALID, 1);
    checkOutput("ab_res_index_before", o_RES_INDEX, 1);
    checkOutput("ab_res_data_before", o_RES_DATA, 32'hC1);
    i_RES_READY = 1'b0;
    i_ABORT = 1'b1;
    d0 = done_cnt;
    tick();
    i_ABORT = 1'b0;
    ar_q.delete();
    applyStimulus();
    i_RES_READY = 1'b1;
    checkOutput("ab_idle", o_BUSY, 0);
    checkOutput("ab_res_valid", o_RES_VALID, 0);
    checkOutput("ab_error", o_ERROR, 1);
    checkOutput("ab_awvalid", bus.o_AWVALID, 0);
    repeat (3) tick();
    checkOutput("ab_no_done", done_cnt - d0, 0);
    checkOutput("ab_res_drained", res_exp_q.size(), 0);

    // A clean frame after the abort starts from index 0 again.
    sendFrame(4, 16'h0200, -1, 0, -1, rc, rs, fb, lb, h2, ac, ea, ba);
    checkOutput("post_err_cleared", ea, 0);
    checkOutput("post_src_ready_cycles", rc, 4);
    recvFrame(4, 32'h000000D0, -1, arc, af, ast, dn);
    checkOutput("post_done_pulses", dn, 1);
    checkOutput("post_error_end", o_ERROR, 0);
    checkOutput("post_idle", o_BUSY, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
